// File: rtl/amber_copro_pkg.sv
// Shared definitions for the CP15 system-control coprocessor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package amber_copro_pkg;

    localparam logic [3:0] CRN_ID         = 4'd0;
    localparam logic [3:0] CRN_FLUSH      = 4'd1;
    localparam logic [3:0] CRN_CTRL       = 4'd2;
    localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
    localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
    localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
    localparam logic [3:0] CRN_FSTATUS    = 4'd6;
    localparam logic [3:0] CRN_FADDR      = 4'd7;
    localparam logic [3:0] CRN_FPOP       = 4'd8;

    localparam logic [1:0] OP_MRC = 2'd1;
    localparam logic [1:0] OP_MCR = 2'd2;

    typedef enum logic [1:0] {
        FLUSH_IDLE      = 2'd0,
        FLUSH_BUSY      = 2'd1,
        FLUSH_BUSY_PEND = 2'd2
    } flush_state_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [31:0] address;
    } fault_entry_t;

endpackage

// File: rtl/copro_fault_fifo.sv
// Fault log FIFO: power-of-two depth (2..16), head is zero when empty.
// Latency: push visible at head one cycle later; count updates same edge.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module copro_fault_fifo
    import amber_copro_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fault_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [4:0]   count,
    output fault_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    fault_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic               push_ok;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    // A pop frees a slot in the same cycle, so a full log still takes the push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Never expose stale storage when the log is empty.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Entry storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/copro15_mmu_ctrl.sv
// CP15 system-control coprocessor: cache control, region attributes, fault log, flush handshake.
// Latency: MRC data and lookup attributes one cycle; flush req one cycle after the CRn 1 write.
// Backpressure: i_fetch_stall freezes decode and fault capture; flush req held until ack.
module copro15_mmu_ctrl
    import amber_copro_pkg::*;
#(
    parameter int          REGION_COUNT = 32,
    parameter int          REGION_SHIFT = 21,
    parameter int          FAULT_DEPTH  = 4,
    parameter logic [31:0] ID_VALUE     = 32'h4180_3002
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_fetch_stall,
    input  logic [3:0]              i_copro_crn,
    input  logic [1:0]              i_copro_operation,
    input  logic [31:0]             i_copro_write_data,
    input  logic                    i_fault,
    input  logic [7:0]              i_fault_status,
    input  logic [31:0]             i_fault_address,
    input  logic [31:0]             i_lookup_address,
    output logic [31:0]             o_copro_read_data,
    output logic                    o_cache_enable,
    output logic [REGION_COUNT-1:0] o_cacheable_area,
    output logic                    o_lookup_cacheable,
    output logic                    o_lookup_updateable,
    output logic                    o_lookup_disruptive,
    output logic                    o_cache_flush_req,
    input  logic                    i_cache_flush_ack,
    output logic                    o_fault_pending
);

    localparam int IDX_W = (REGION_COUNT > 1) ? $clog2(REGION_COUNT) : 1;

    logic [2:0]              ctrl;
    logic [REGION_COUNT-1:0] cacheable;
    logic [REGION_COUNT-1:0] updateable;
    logic [REGION_COUNT-1:0] disruptive;
    logic                    overflow;
    flush_state_t            flush_state;
    logic [31:0]             read_next;

    logic mrc;
    logic mcr;
    logic flush_wr;
    logic ack_ok;
    logic fault_push;
    logic fault_pop;
    logic fault_full;
    logic fault_empty;
    logic [4:0]   fault_count;
    fault_entry_t fault_head;
    fault_entry_t fault_in;

    assign mrc = !i_fetch_stall && (i_copro_operation == OP_MRC);
    assign mcr = !i_fetch_stall && (i_copro_operation == OP_MCR);

    assign o_cache_enable   = ctrl[0];
    assign o_cacheable_area = cacheable;
    assign o_fault_pending  = !fault_empty;

    // ---------------- fault log ----------------
    assign fault_push = !i_fetch_stall && i_fault;
    assign fault_pop  = mcr && (i_copro_crn == CRN_FPOP) && i_copro_write_data[0];
    assign fault_in   = '{status: i_fault_status, address: i_fault_address};

    copro_fault_fifo #(.DEPTH(FAULT_DEPTH)) u_fault_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push       (fault_push),
        .push_entry (fault_in),
        .pop        (fault_pop),
        .full       (fault_full),
        .empty      (fault_empty),
        .count      (fault_count),
        .head       (fault_head)
    );

    // Sticky overflow: a drop only happens when full with no pop freeing a slot; a new drop beats a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow <= 1'b0;
        end else if (fault_push && fault_full && !fault_pop) begin
            overflow <= 1'b1;
        end else if (mcr && (i_copro_crn == CRN_FPOP) && i_copro_write_data[1]) begin
            overflow <= 1'b0;
        end
    end

    // ---------------- register file ----------------
    // MCR writes to the control and area registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctrl       <= 3'd0;
            cacheable  <= '0;
            updateable <= '0;
            disruptive <= '0;
        end else if (mcr) begin
            case (i_copro_crn)
                CRN_CTRL:       ctrl       <= i_copro_write_data[2:0];
                CRN_CACHEABLE:  cacheable  <= i_copro_write_data[REGION_COUNT-1:0];
                CRN_UPDATEABLE: updateable <= i_copro_write_data[REGION_COUNT-1:0];
                CRN_DISRUPTIVE: disruptive <= i_copro_write_data[REGION_COUNT-1:0];
                default: ;
            endcase
        end
    end

    // MRC source select.
    always_comb begin
        read_next = 32'd0;
        case (i_copro_crn)
            CRN_ID:         read_next = ID_VALUE;
            CRN_FLUSH:      read_next = {30'd0, flush_state == FLUSH_BUSY_PEND, flush_state != FLUSH_IDLE};
            CRN_CTRL:       read_next = {29'd0, ctrl};
            CRN_CACHEABLE:  read_next = 32'(cacheable);
            CRN_UPDATEABLE: read_next = 32'(updateable);
            CRN_DISRUPTIVE: read_next = 32'(disruptive);
            CRN_FSTATUS:    read_next = {overflow, 3'd0, fault_count[3:0], 16'd0, fault_head.status};
            CRN_FADDR:      read_next = fault_head.address;
            default:        read_next = 32'd0;
        endcase
    end

    // Read data is captured only on an MRC and holds otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_copro_read_data <= 32'd0;
        end else if (mrc) begin
            o_copro_read_data <= read_next;
        end
    end

    // ---------------- flush handshake ----------------
    assign flush_wr = mcr && (i_copro_crn == CRN_FLUSH);
    // An ack only counts against a visible request, so stray acks in IDLE or the gap cycle do nothing.
    assign ack_ok   = i_cache_flush_ack && o_cache_flush_req;

    // Flush FSM; a completing ack always drops req for one cycle, and a queued flush then reasserts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            flush_state       <= FLUSH_IDLE;
            o_cache_flush_req <= 1'b0;
        end else begin
            case (flush_state)
                FLUSH_IDLE: begin
                    o_cache_flush_req <= flush_wr;
                    if (flush_wr) begin
                        flush_state <= FLUSH_BUSY;
                    end
                end
                FLUSH_BUSY: begin
                    if (ack_ok) begin
                        o_cache_flush_req <= 1'b0;
                        flush_state       <= flush_wr ? FLUSH_BUSY : FLUSH_IDLE;
                    end else begin
                        o_cache_flush_req <= 1'b1;
                        if (flush_wr) begin
                            flush_state <= FLUSH_BUSY_PEND;
                        end
                    end
                end
                FLUSH_BUSY_PEND: begin
                    if (ack_ok) begin
                        o_cache_flush_req <= 1'b0;
                        flush_state       <= FLUSH_BUSY;
                    end else begin
                        o_cache_flush_req <= 1'b1;
                    end
                end
                default: begin
                    o_cache_flush_req <= 1'b0;
                    flush_state       <= FLUSH_IDLE;
                end
            endcase
        end
    end

    // ---------------- attribute lookup ----------------
    logic [31:0]             region;
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic [REGION_COUNT-1:0] cacheable_sh;
    logic [REGION_COUNT-1:0] updateable_sh;
    logic [REGION_COUNT-1:0] disruptive_sh;

    assign region        = i_lookup_address >> REGION_SHIFT;
    assign idx           = region[IDX_W-1:0];
    // Any region bit above the index field means the address is past the last region.
    assign in_range      = ((region >> IDX_W) == 32'd0) &&
                           ({{(32-IDX_W){1'b0}}, idx} < 32'(REGION_COUNT));
    assign cacheable_sh  = cacheable  >> idx;
    assign updateable_sh = updateable >> idx;
    assign disruptive_sh = disruptive >> idx;

    // Registered lookup; uses the area registers as they stood before any same-edge MCR.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_lookup_cacheable  <= 1'b0;
            o_lookup_updateable <= 1'b0;
            o_lookup_disruptive <= 1'b0;
        end else begin
            o_lookup_cacheable  <= in_range && cacheable_sh[0];
            o_lookup_updateable <= in_range && updateable_sh[0];
            o_lookup_disruptive <= in_range && disruptive_sh[0];
        end
    end

endmodule

// File: tb/tb_copro15_mmu_ctrl.sv
// Directed self-checking bench for copro15_mmu_ctrl (REGION_COUNT = 8, FAULT_DEPTH = 4).
// Latency: inputs applied before a posedge, outputs sampled 1 time unit after it.
// Backpressure: fetch stall and flush ack driven directly from the scenario tasks.
module tb_copro15_mmu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_fetch_stall = 1'b0;
    logic [3:0]  i_copro_crn = 4'd0;
    logic [1:0]  i_copro_operation = 2'd0;
    logic [31:0] i_copro_write_data = 32'd0;
    logic        i_fault = 1'b0;
    logic [7:0]  i_fault_status = 8'd0;
    logic [31:0] i_fault_address = 32'd0;
    logic [31:0] i_lookup_address = 32'd0;
    logic [31:0] o_copro_read_data;
    logic        o_cache_enable;
    logic [7:0]  o_cacheable_area;
    logic        o_lookup_cacheable;
    logic        o_lookup_updateable;
    logic        o_lookup_disruptive;
    logic        o_cache_flush_req;
    logic        i_cache_flush_ack = 1'b0;
    logic        o_fault_pending;

    int checks = 0;
    int errors = 0;

    copro15_mmu_ctrl #(
        .REGION_COUNT (8),
        .REGION_SHIFT (21),
        .FAULT_DEPTH  (4),
        .ID_VALUE     (32'h4180_3002)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_fetch_stall       (i_fetch_stall),
        .i_copro_crn         (i_copro_crn),
        .i_copro_operation   (i_copro_operation),
        .i_copro_write_data  (i_copro_write_data),
        .i_fault             (i_fault),
        .i_fault_status      (i_fault_status),
        .i_fault_address     (i_fault_address),
        .i_lookup_address    (i_lookup_address),
        .o_copro_read_data   (o_copro_read_data),
        .o_cache_enable      (o_cache_enable),
        .o_cacheable_area    (o_cacheable_area),
        .o_lookup_cacheable  (o_lookup_cacheable),
        .o_lookup_updateable (o_lookup_updateable),
        .o_lookup_disruptive (o_lookup_disruptive),
        .o_cache_flush_req   (o_cache_flush_req),
        .i_cache_flush_ack   (i_cache_flush_ack),
        .o_fault_pending     (o_fault_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic mcr(input logic [3:0] crn, input logic [31:0] data);
        i_copro_operation  = 2'd2;
        i_copro_crn        = crn;
        i_copro_write_data = data;
        tick();
        i_copro_operation  = 2'd0;
    endtask

    task automatic mrc(input logic [3:0] crn);
        i_copro_operation = 2'd1;
        i_copro_crn       = crn;
        tick();
        i_copro_operation = 2'd0;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({o_copro_read_data, o_cache_enable, o_cacheable_area, o_lookup_cacheable,
             o_lookup_updateable, o_lookup_disruptive, o_cache_flush_req, o_fault_pending} !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h ce=%b ca=%h lk=%b%b%b req=%b pend=%b, expected all 0",
                     o_copro_read_data, o_cache_enable, o_cacheable_area, o_lookup_cacheable,
                     o_lookup_updateable, o_lookup_disruptive, o_cache_flush_req, o_fault_pending);
        end
        i_rst_n = 1'b1;
        tick();
        mrc(4'd0);
        checks++;
        if (o_copro_read_data !== 32'h4180_3002) begin
            errors++;
            $display("FAIL id_read: got %h expected %h", o_copro_read_data, 32'h4180_3002);
        end
        mrc(4'd3);
        checks++;
        if (o_copro_read_data !== 32'd0) begin
            errors++;
            $display("FAIL cacheable_reset_read: got %h expected 0", o_copro_read_data);
        end
        mrc(4'd7);
        checks++;
        if (o_copro_read_data !== 32'd0) begin
            errors++;
            $display("FAIL faddr_empty_read: got %h expected 0", o_copro_read_data);
        end
    endtask

    task automatic test_lookup;
        mcr(4'd3, 32'h0000_0005);
        checks++;
        if (o_cacheable_area !== 8'h05) begin
            errors++;
            $display("FAIL cacheable_area_out: got %h expected 05", o_cacheable_area);
        end
        i_lookup_address = 32'h0020_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b0) begin
            errors++;
            $display("FAIL lookup_region1: got %b expected 0", o_lookup_cacheable);
        end
        i_lookup_address = 32'h0040_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b1) begin
            errors++;
            $display("FAIL lookup_region2: got %b expected 1", o_lookup_cacheable);
        end
        i_lookup_address = 32'h4000_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b0) begin
            errors++;
            $display("FAIL lookup_far_out_of_range: got %b expected 0", o_lookup_cacheable);
        end
        // Lookup in the same cycle as an MCR sees the old register value.
        i_lookup_address   = 32'h0000_0000;
        i_copro_operation  = 2'd2;
        i_copro_crn        = 4'd3;
        i_copro_write_data = 32'hFFFF_FFFF;
        tick();
        i_copro_operation  = 2'd0;
        checks++;
        if (o_lookup_cacheable !== 1'b1) begin
            errors++;
            $display("FAIL lookup_old_value: got %b expected 1", o_lookup_cacheable);
        end
        i_lookup_address = 32'h0020_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b1) begin
            errors++;
            $display("FAIL lookup_new_value: got %b expected 1", o_lookup_cacheable);
        end
        i_lookup_address = 32'h00E0_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b1) begin
            errors++;
            $display("FAIL lookup_last_region: got %b expected 1", o_lookup_cacheable);
        end
        i_lookup_address = 32'h0100_0000;
        tick();
        checks++;
        if (o_lookup_cacheable !== 1'b0) begin
            errors++;
            $display("FAIL lookup_first_out_of_range: got %b expected 0", o_lookup_cacheable);
        end
        mrc(4'd3);
        checks++;
        if (o_copro_read_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL cacheable_truncated_read: got %h expected 000000ff", o_copro_read_data);
        end
        mcr(4'd4, 32'h0000_0002);
        mcr(4'd5, 32'h0000_0004);
        i_lookup_address = 32'h0020_0000;
        tick();
        checks++;
        if ({o_lookup_updateable, o_lookup_disruptive} !== 2'b10) begin
            errors++;
            $display("FAIL lookup_upd_region1: got %b%b expected 10", o_lookup_updateable, o_lookup_disruptive);
        end
        i_lookup_address = 32'h0040_0000;
        tick();
        checks++;
        if ({o_lookup_updateable, o_lookup_disruptive} !== 2'b01) begin
            errors++;
            $display("FAIL lookup_dis_region2: got %b%b expected 01", o_lookup_updateable, o_lookup_disruptive);
        end
    endtask

    task automatic test_fault_log;
        for (int i = 0; i < 5; i++) begin
            i_fault         = 1'b1;
            i_fault_status  = 8'(8'h11 + i);
            i_fault_address = 32'(32'h100 * (i + 1));
            tick();
        end
        i_fault = 1'b0;
        checks++;
        if (o_fault_pending !== 1'b1) begin
            errors++;
            $display("FAIL fault_pending: got %b expected 1", o_fault_pending);
        end
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'h8400_0011) begin
            errors++;
            $display("FAIL fstatus_overflow: got %h expected 84000011", o_copro_read_data);
        end
        mrc(4'd7);
        checks++;
        if (o_copro_read_data !== 32'h0000_0100) begin
            errors++;
            $display("FAIL faddr_head: got %h expected 00000100", o_copro_read_data);
        end
        mcr(4'd8, 32'd1);
        mcr(4'd8, 32'd1);
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'h8200_0013) begin
            errors++;
            $display("FAIL fstatus_after_pops: got %h expected 82000013", o_copro_read_data);
        end
        mrc(4'd7);
        checks++;
        if (o_copro_read_data !== 32'h0000_0300) begin
            errors++;
            $display("FAIL faddr_after_pops: got %h expected 00000300", o_copro_read_data);
        end
        mcr(4'd8, 32'd2);
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'h0200_0013) begin
            errors++;
            $display("FAIL overflow_clear: got %h expected 02000013", o_copro_read_data);
        end
    endtask

    task automatic test_pop_push_full;
        // Log holds 0x13, 0x14; fill to 0x13, 0x14, 0x16, 0x17.
        i_fault = 1'b1; i_fault_status = 8'h16; i_fault_address = 32'h600;
        tick();
        i_fault_status = 8'h17; i_fault_address = 32'h700;
        tick();
        i_fault_status = 8'h18; i_fault_address = 32'h800;
        i_copro_operation  = 2'd2;
        i_copro_crn        = 4'd8;
        i_copro_write_data = 32'd1;
        tick();
        i_copro_operation = 2'd0;
        i_fault           = 1'b0;
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'h0400_0014) begin
            errors++;
            $display("FAIL pop_push_full: got %h expected 04000014", o_copro_read_data);
        end
        mcr(4'd8, 32'd1);
        mcr(4'd8, 32'd1);
        mcr(4'd8, 32'd1);
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'h0100_0018) begin
            errors++;
            $display("FAIL tail_entry_status: got %h expected 01000018", o_copro_read_data);
        end
        mrc(4'd7);
        checks++;
        if (o_copro_read_data !== 32'h0000_0800) begin
            errors++;
            $display("FAIL tail_entry_addr: got %h expected 00000800", o_copro_read_data);
        end
        mcr(4'd8, 32'd1);
        mcr(4'd8, 32'd1);
        mrc(4'd6);
        checks++;
        if (o_copro_read_data !== 32'd0 || o_fault_pending !== 1'b0) begin
            errors++;
            $display("FAIL empty_after_pop: got %h pend=%b expected 0 pend=0", o_copro_read_data, o_fault_pending);
        end
        mrc(4'd7);
        checks++;
        if (o_copro_read_data !== 32'd0) begin
            errors++;
            $display("FAIL empty_faddr: got %h expected 0", o_copro_read_data);
        end
    endtask

    task automatic test_flush;
        mcr(4'd1, 32'd0);
        checks++;
        if (o_cache_flush_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_rise: got %b expected 1", o_cache_flush_req);
        end
        mcr(4'd1, 32'd0);
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd3) begin
            errors++;
            $display("FAIL flush_pend_read: got %h expected 3", o_copro_read_data);
        end
        i_cache_flush_ack = 1'b1;
        tick();
        i_cache_flush_ack = 1'b0;
        checks++;
        if (o_cache_flush_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_gap: got %b expected 0", o_cache_flush_req);
        end
        tick();
        checks++;
        if (o_cache_flush_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_reassert: got %b expected 1", o_cache_flush_req);
        end
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd1) begin
            errors++;
            $display("FAIL flush_busy_read: got %h expected 1", o_copro_read_data);
        end
        i_cache_flush_ack = 1'b1;
        tick();
        i_cache_flush_ack = 1'b0;
        checks++;
        if (o_cache_flush_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: got %b expected 0", o_cache_flush_req);
        end
        i_cache_flush_ack = 1'b1;
        tick();
        i_cache_flush_ack = 1'b0;
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd0 || o_cache_flush_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ack: got rd=%h req=%b expected 0 0", o_copro_read_data, o_cache_flush_req);
        end
        // Write and ack together in BUSY: queued, not lost.
        mcr(4'd1, 32'd0);
        i_copro_operation = 2'd2;
        i_copro_crn       = 4'd1;
        i_cache_flush_ack = 1'b1;
        tick();
        i_copro_operation = 2'd0;
        i_cache_flush_ack = 1'b0;
        checks++;
        if (o_cache_flush_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_wr_ack_gap: got %b expected 0", o_cache_flush_req);
        end
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd1 || o_cache_flush_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_wr_ack_queued: got rd=%h req=%b expected 1 1", o_copro_read_data, o_cache_flush_req);
        end
        i_cache_flush_ack = 1'b1;
        tick();
        i_cache_flush_ack = 1'b0;
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd0) begin
            errors++;
            $display("FAIL flush_wr_ack_final: got %h expected 0", o_copro_read_data);
        end
    endtask

    task automatic test_stall;
        mrc(4'd0);
        i_fetch_stall = 1'b1;
        mcr(4'd2, 32'd1);
        mrc(4'd3);
        i_fault = 1'b1; i_fault_status = 8'h99; i_fault_address = 32'h900;
        tick();
        i_fault = 1'b0;
        i_fetch_stall = 1'b0;
        checks++;
        if (o_cache_enable !== 1'b0) begin
            errors++;
            $display("FAIL stall_ctrl_write: got %b expected 0", o_cache_enable);
        end
        checks++;
        if (o_copro_read_data !== 32'h4180_3002) begin
            errors++;
            $display("FAIL stall_read_hold: got %h expected 41803002", o_copro_read_data);
        end
        checks++;
        if (o_fault_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_fault_capture: got %b expected 0", o_fault_pending);
        end
        mcr(4'd2, 32'h0000_0007);
        mrc(4'd2);
        checks++;
        if (o_cache_enable !== 1'b1 || o_copro_read_data !== 32'd7) begin
            errors++;
            $display("FAIL ctrl_write: got ce=%b rd=%h expected 1 7", o_cache_enable, o_copro_read_data);
        end
    endtask

    task automatic test_reset_during_flush;
        mcr(4'd1, 32'd0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        checks++;
        if (o_cache_flush_req !== 1'b0 || o_cache_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_req: got req=%b ce=%b expected 0 0", o_cache_flush_req, o_cache_enable);
        end
        i_cache_flush_ack = 1'b1;
        tick();
        i_cache_flush_ack = 1'b0;
        mrc(4'd1);
        checks++;
        if (o_copro_read_data !== 32'd0 || o_cache_flush_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_ack: got rd=%h req=%b expected 0 0", o_copro_read_data, o_cache_flush_req);
        end
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_fault_log();
        test_pop_push_full();
        test_flush();
        test_stall();
        test_reset_during_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/copro15_mmu_ctrl.md
Name: copro15_mmu_ctrl

Overview:
- Parametrised next-generation system-control coprocessor (CP15) for the Amber core. It sits beside the execute stage on the MCR/MRC path.
- Provides cache control, plus per-region cacheable, updateable and disruptive attribute registers with a configurable region count and size.
- Adds a multi-entry fault log FIFO, a registered per-address attribute lookup port, and a req/ack cache-flush handshake with one-deep flush queueing.

Parameters:
REGION_COUNT, 32, number of attribute regions (width of each area register, 1..32)
REGION_SHIFT, 21, log2 of region size in bytes (default 2 MB)
FAULT_DEPTH, 4, fault log entries (power of two, 2..16)
ID_VALUE, 32'h4180_3002, value returned by the CRn 0 read

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_fetch_stall  in  1  freezes MCR/MRC decode and fault capture
i_copro_crn  in  4  register number
i_copro_operation  in  2  1 = MRC (read), 2 = MCR (write), other = none
i_copro_write_data  in  32  MCR data
i_fault  in  1  fault strobe
i_fault_status  in  8  fault status
i_fault_address  in  32  faulting address
i_lookup_address  in  32  address to classify
o_copro_read_data  out  32  MRC result
o_cache_enable  out  1  control bit 0
o_cacheable_area  out  REGION_COUNT  cacheable register
o_lookup_cacheable / o_lookup_updateable / o_lookup_disruptive  out  1 each  attributes of i_lookup_address
o_cache_flush_req  out  1  flush request to cache
i_cache_flush_ack  in  1  one-cycle flush-complete pulse
o_fault_pending  out  1  fault log non-empty

Behaviour:
- Reset (i_rst_n low at a clock edge) clears:
  - all registers, outputs and read data to 0;
  - fault log to empty, overflow flag to 0;
  - flush FSM to IDLE, abandoning any outstanding request;
  - lookup outputs to 0.
- All MCR/MRC decode and fault capture happen only when i_fetch_stall = 0. The flush FSM and the lookup path ignore i_fetch_stall.
- Register map:
  - CRn 0, R: ID_VALUE.
  - CRn 1, W: start a cache flush. R: {30'd0, pend, busy}.
  - CRn 2, RW: control [2:0] (bit 0 = cache enable).
  - CRn 3, RW: cacheable area.
  - CRn 4, RW: updateable area.
  - CRn 5, RW: disruptive area.
  - CRn 6, R: {overflow, 3'd0, count[3:0], 16'd0, head status[7:0]}.
  - CRn 7, R: head fault address.
  - CRn 8, W: bit 0 = 1 pops the log head; bit 1 = 1 clears overflow.
  - Other CRn: reads return 0, writes are ignored.
- Area registers are REGION_COUNT bits wide. Writes take write_data[REGION_COUNT-1:0]; reads zero-extend.
- Read latency: data appears in o_copro_read_data one cycle after the decode edge. It holds while stalled and holds between reads.
- Reading an empty log returns status 0 and address 0 (never stale data).
- Fault log (FIFO, FAULT_DEPTH entries):
  - i_fault pushes {status, address}.
  - Pushing while full drops the entry and sets overflow (sticky).
  - Popping while empty is ignored.
  - Simultaneous pop and push: both take effect and count is unchanged. When full, the push is accepted (not an overflow).
  - o_fault_pending = (count != 0).
- Flush FSM has three states: IDLE, BUSY, BUSY_PEND.
  - IDLE + CRn 1 write -> BUSY. o_cache_flush_req rises the next cycle and stays high until ack.
  - BUSY + ack -> IDLE; req is low the following cycle.
  - BUSY + CRn 1 write (no ack) -> BUSY_PEND.
  - BUSY_PEND + ack -> BUSY; req drops for exactly one cycle, then reasserts.
  - Writes to CRn 1 in BUSY_PEND are merged.
  - Write and ack in the same cycle in BUSY -> BUSY_PEND then BUSY, i.e. the write is queued, never lost.
  - Ack in IDLE is ignored.
  - busy = state != IDLE; pend = state == BUSY_PEND.
- Lookup:
  - idx = i_lookup_address >> REGION_SHIFT.
  - If idx < REGION_COUNT, outputs = area bit [idx] of each register; otherwise all three outputs are 0.
  - Registered: one-cycle latency, using the register values before any same-cycle MCR update.
- Lookup arithmetic is unsigned. Index width is clog2(REGION_COUNT); the upper address bits are checked for non-zero to detect out-of-range addresses.

Decomposition:
- Package amber_copro_pkg holds:
  - CRn constants (CRN_ID, CRN_FLUSH, CRN_CTRL, CRN_CACHEABLE, CRN_UPDATEABLE, CRN_DISRUPTIVE, CRN_FSTATUS, CRN_FADDR, CRN_FPOP);
  - operation codes OP_MRC = 1, OP_MCR = 2;
  - the flush state enum;
  - a fault entry struct {status[7:0], address[31:0]}.
- Sub-module copro_fault_fifo (parametrised on depth; push/pop/full/empty/count/head) holds the fault log.

Test Plan:
- Reset, then MRC CRn 0, 3 and 7 -> read data 32'h41803002, 0, 0; all outputs 0.
- MCR CRn 3 = 32'h0000_0005, then lookup 0x0020_0000 and 0x0040_0000 -> cacheable = 0 then 1. Lookup 0x4000_0000 with REGION_COUNT = 8 -> 0.
- Push 5 faults (status 0x11..0x15, address 0x100..0x500) with FAULT_DEPTH = 4 -> CRn 6 reads overflow = 1, count = 4, status 0x11. Pop twice -> head 0x13/0x300. Write CRn 8 = 2 -> overflow = 0.
- Pop and push in the same cycle on a full log -> count stays 4, new entry appears at the tail, overflow unchanged.
- MCR CRn 1, a second MCR CRn 1 before ack, then ack -> req low for 1 cycle, reasserts, second ack returns to IDLE. CRn 1 reads 3, then 1, then 0.
- Assert i_fetch_stall during an MCR CRn 2 = 1 -> no update. Assert reset while req = 1 -> req is 0 next cycle and a later ack is ignored.
